// File: rtl/xc_aes_pkg.sv
// ---------------------------------------------------------------------------
// xc_aes_pkg
// Shared definitions for the sequential AES SubBytes unit:
//   - FSM state enumeration (IDLE / BUSY / DONE)
//   - number of bytes per word and the last byte index
//   - forward and inverse AES S-box tables with lookup helpers
// ---------------------------------------------------------------------------
package xc_aes_pkg;

    localparam int unsigned BYTE_COUNT = 4;
    localparam logic [1:0]  LAST_BYTE  = 2'(BYTE_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [7:0] SBOX_FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] SBOX_INV [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
        return SBOX_FWD[b];
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] b);
        return SBOX_INV[b];
    endfunction

endpackage

// File: rtl/xc_aessub_seq_if.sv
// ---------------------------------------------------------------------------
// xc_aessub_seq_if
// Request/response bundle of the sequential SubBytes unit.
//   valid  : request valid, held by the requester until ready is seen
//   rs1    : source register 1 (bytes 0 and 2 of the operand word)
//   rs2    : source register 2 (bytes 1 and 3 of the operand word)
//   enc    : 1 = forward S-box, 0 = inverse S-box
//   rot    : 1 = rotate the result right by one byte
//   ready  : one-cycle completion pulse
//   result : SubBytes result, valid only while ready is high (0 otherwise)
// Modports: master (requester) and slave (the unit).
// ---------------------------------------------------------------------------
interface xc_aessub_seq_if;
    logic        valid;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        enc;
    logic        rot;
    logic        ready;
    logic [31:0] result;

    modport master (output valid, rs1, rs2, enc, rot, input ready, result);
    modport slave  (input valid, rs1, rs2, enc, rot, output ready, result);
endinterface

// File: rtl/xc_aes_sbox.sv
// ---------------------------------------------------------------------------
// xc_aes_sbox
// Combinational single-byte AES S-box.
//   in_i  : byte to substitute
//   enc_i : 1 = forward S-box, 0 = inverse S-box
//   out_o : substituted byte
// Macro XC_AESSUB_DEC_EN: when defined the inverse S-box is built in; when
// undefined the inverse path is absent and enc_i=0 yields 8'h00.
// ---------------------------------------------------------------------------
module xc_aes_sbox
    import xc_aes_pkg::*;
(
    input  logic [7:0] in_i,
    input  logic       enc_i,
    output logic [7:0] out_o
);

`ifdef XC_AESSUB_DEC_EN
    assign out_o = enc_i ? sbox_fwd(in_i) : sbox_inv(in_i);
`else
    assign out_o = enc_i ? sbox_fwd(in_i) : 8'h00;
`endif

endmodule

// File: rtl/xc_aessub_seq.sv
// ---------------------------------------------------------------------------
// xc_aessub_seq
// Sequential AES SubBytes: substitutes the four bytes of the operand word
// {rs2[31:24], rs1[23:16], rs2[15:8], rs1[7:0]} one byte per cycle through a
// single shared S-box, then presents the word (optionally rotated right by
// 8 bits) together with a one-cycle ready pulse.
//   g_clk    : core clock, rising edge
//   g_resetn : asynchronous active-low reset
//   bus      : xc_aessub_seq_if.slave (valid/rs1/rs2/enc/rot in, ready/result out)
// Timing: accepted at edge N -> BUSY for 4 cycles -> DONE (ready=1) -> IDLE.
// Dropping valid while BUSY abandons the operation without a ready pulse.
// Macro XC_AESSUB_DEC_EN enables the inverse S-box (see xc_aes_sbox).
// ---------------------------------------------------------------------------
module xc_aessub_seq
    import xc_aes_pkg::*;
(
    input  logic          g_clk,
    input  logic          g_resetn,
    xc_aessub_seq_if.slave bus
);

    state_e      state_q, state_d;
    logic [1:0]  cnt_q,   cnt_d;
    logic [31:0] w_q,     w_d;
    logic        enc_q,   enc_d;
    logic        rot_q,   rot_d;
    logic [31:0] res_q,   res_d;
    logic [7:0]  sbox_in;
    logic [7:0]  sbox_out;

    // Operand bytes that never reach the operand word.
    logic unused_opnd;
    assign unused_opnd = ^{bus.rs1[31:24], bus.rs1[15:8], bus.rs2[23:16], bus.rs2[7:0]};

    assign sbox_in = w_q[{cnt_q, 3'b000} +: 8];

    xc_aes_sbox u_sbox (
        .in_i  (sbox_in),
        .enc_i (enc_q),
        .out_o (sbox_out)
    );

    always_comb begin
        // NOTE: every _d gets a hold default first, so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
        enc_d   = enc_q;
        rot_d   = rot_q;
        res_d   = res_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.valid) begin
                    state_d = ST_BUSY;
                    cnt_d   = 2'd0;
                    w_d     = {bus.rs2[31:24], bus.rs1[23:16], bus.rs2[15:8], bus.rs1[7:0]};
                    enc_d   = bus.enc;
                    rot_d   = bus.rot;
                    res_d   = '0;
                end
            end
            ST_BUSY: begin
                if (!bus.valid) begin
                    // Requester withdrew: abandon without a ready pulse.
                    state_d = ST_IDLE;
                    cnt_d   = 2'd0;
                end else begin
                    res_d[{cnt_q, 3'b000} +: 8] = sbox_out;
                    if (cnt_q == LAST_BYTE) begin
                        state_d = ST_DONE;
                        cnt_d   = 2'd0;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            w_q     <= '0;
            enc_q   <= 1'b0;
            rot_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            enc_q   <= enc_d;
            rot_q   <= rot_d;
            res_q   <= res_d;
        end
    end

    // Result is forced to zero outside DONE; rotation is applied on output.
    assign bus.ready  = (state_q == ST_DONE);
    assign bus.result = !bus.ready ? 32'h0 :
                        rot_q      ? {res_q[7:0], res_q[31:8]} : res_q;

endmodule

// File: doc/xc_aessub_seq.md
XC_AESSUB_SEQ -- requirements
Module: xc_aessub_seq

Interface
REQ-001 Parameters: none; behaviour is fixed at compile time by the macro in Configuration.
REQ-002 g_clk  input  1  core clock; all state updates on rising edge.
REQ-003 g_resetn  input  1  reset, asynchronous, active-low.
REQ-004 valid  input  1  request valid; held high by requester until ready seen.
REQ-005 rs1  input  32  source register 1.
REQ-006 rs2  input  32  source register 2.
REQ-007 enc  input  1  1 = forward SubBytes (encrypt), 0 = inverse (decrypt).
REQ-008 rot  input  1  1 = rotate result right by 8 bits.
REQ-009 ready  output  1  one-cycle pulse; result valid in the same cycle.
REQ-010 result  output  32  SubBytes result.

Function
REQ-011 Operand word w SHALL be {rs2[31:24], rs1[23:16], rs2[15:8], rs1[7:0]}, captured with enc and rot on IDLE->BUSY.
REQ-012 Result byte i SHALL be S(w byte i), where S is the AES S-box if enc=1, the inverse S-box if enc=0.
REQ-013 If rot=1, result SHALL be the 4-byte value rotated right by 8 bits ({b0,b3,b2,b1}).
REQ-014 A single shared one-byte S-box SHALL be used; one byte processed per BUSY cycle, byte counter 0..3, byte 0 first.
REQ-015 States IDLE, BUSY, DONE; IDLE->BUSY when valid=1; BUSY stays 4 cycles (counter 0..3) then ->DONE; DONE->IDLE unconditionally.
REQ-016 Latency: valid first high at edge N -> ready=1 during cycle N+5 only.
REQ-017 ready SHALL be high only in DONE; result SHALL be 0 outside DONE.
REQ-018 valid low while BUSY SHALL abort: ->IDLE next edge, counter cleared, no ready pulse.
REQ-019 Operand changes while BUSY SHALL be ignored (captured copies used).
REQ-020 valid high in the DONE cycle SHALL not start a new operation; a new request is accepted only from IDLE (no back-to-back within DONE).
REQ-021 Counter SHALL be 2 bits and never wrap past 3 within one operation.

Reset
REQ-022 g_resetn low SHALL immediately force IDLE, counter 0, captured operands/partial result 0, ready 0, result 0.
REQ-023 Reset mid-operation SHALL discard the operation; no ready pulse after release until a fresh request.

Configuration
REQ-024 XC_AESSUB_DEC_EN defined: inverse S-box compiled in, enc=0 behaves per REQ-012.
REQ-025 XC_AESSUB_DEC_EN undefined: inverse S-box absent; enc=0 requests SHALL complete with identical timing and result 32'h0.

Structure
REQ-026 Package xc_aes_pkg SHALL hold the forward and inverse S-box tables, the FSM state enum and the byte-count constant (4).
REQ-027 Sub-module xc_aes_sbox (8-bit in, enc select, 8-bit out, combinational) SHALL be instantiated exactly once.

Verification
REQ-028 rs1=0, rs2=0, enc=1, rot=0, valid held -> ready only in cycle N+5, result=0x63636363.
REQ-029 rs1=0x00000053, rs2=0x00000100, enc=1, rot=0 -> 0x63637CED; same with rot=1 -> 0xED63637C.
REQ-030 rs1=0x00000063, rs2=0x00006300, enc=0, rot=0 -> 0x52520000 with macro; 0x00000000 without macro, same latency.
REQ-031 Valid dropped at N+2 -> no ready through N+10; fresh request at N+3 -> ready at N+8.
REQ-032 g_resetn pulsed low at N+3 -> ready and result 0 immediately, no ready pulse afterwards; fresh request after release completes normally.
REQ-033 Operands changed each BUSY cycle -> result matches values captured at N.
